// File: rtl/regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard.
// Decode reads operands and busy status. Writeback retires destinations. Flush drops all tracking.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CNTW   = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   reg1,
    input  logic [AW-1:0]   reg2,
    output logic [XLEN-1:0] reg1val,
    output logic [XLEN-1:0] reg2val,
    output logic            reg1busy,
    output logic            reg2busy,
    output logic            hazard,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   regD,
    input  logic [XLEN-1:0] write_data,
    input  logic            regwrite,
    input  logic            flush,
    output logic            sb_err
);

    localparam logic            BYP   = (BYPASS != 0);
    localparam logic [CNTW-1:0] CMAX  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CONE  = CNTW'(1);

    logic [XLEN-1:0] regs     [1:NREG-1];
    logic [CNTW-1:0] cnt      [1:NREG-1];
    logic [CNTW-1:0] cnt_next [1:NREG-1];
    logic            err_next;
    logic            fwd1, fwd2;

    always_comb begin
        err_next = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            logic inc, dec;
            inc         = issue_valid && (issue_rd == AW'(r));
            dec         = regwrite && (regD == AW'(r));
            cnt_next[r] = cnt[r];
            if (flush) begin
                cnt_next[r] = '0;
            end else if (inc && !dec) begin
                if (cnt[r] == CMAX) err_next = 1'b1;
                else                cnt_next[r] = cnt[r] + CONE;
            end else if (dec && !inc) begin
                if (cnt[r] == '0) err_next = 1'b1;
                else              cnt_next[r] = cnt[r] - CONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt[r] <= cnt_next[r];
            end
            if (regwrite && (regD != '0)) regs[regD] <= write_data;
            if (err_next) sb_err <= 1'b1;
        end
    end

    // Forwarding is gated by rst so that reads return zero throughout reset.
    always_comb begin
        fwd1 = BYP && !rst && regwrite && (regD == reg1) && (reg1 != '0);
        fwd2 = BYP && !rst && regwrite && (regD == reg2) && (reg2 != '0);

        reg1val  = '0;
        reg1busy = 1'b0;
        if (reg1 != '0) begin
            reg1val  = fwd1 ? write_data : regs[reg1];
            reg1busy = (cnt[reg1] != '0) && !(fwd1 && (cnt[reg1] == CONE));
        end

        reg2val  = '0;
        reg2busy = 1'b0;
        if (reg2 != '0) begin
            reg2val  = fwd2 ? write_data : regs[reg2];
            reg2busy = (cnt[reg2] != '0) && !(fwd2 && (cnt[reg2] == CONE));
        end

        hazard = reg1busy | reg2busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a forwarding and a non-forwarding instance share stimulus.
// Both are compared against an array-based reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int CNTW = 2;
    localparam int AW   = 5;
    localparam int MAXC = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   reg1 = '0, reg2 = '0, issue_rd = '0, regD = '0;
    logic            issue_valid = 1'b0, regwrite = 1'b0, flush = 1'b0;
    logic [XLEN-1:0] write_data = '0;

    logic [XLEN-1:0] b_r1val, b_r2val, n_r1val, n_r2val;
    logic            b_r1busy, b_r2busy, b_hazard, b_err;
    logic            n_r1busy, n_r2busy, n_hazard, n_err;

    logic [XLEN-1:0] mreg [NREG];
    int              mcnt [NREG];
    bit              merr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .reg1(reg1), .reg2(reg2),
        .reg1val(b_r1val), .reg2val(b_r2val), .reg1busy(b_r1busy), .reg2busy(b_r2busy),
        .hazard(b_hazard), .issue_valid(issue_valid), .issue_rd(issue_rd), .regD(regD),
        .write_data(write_data), .regwrite(regwrite), .flush(flush), .sb_err(b_err)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .reg1(reg1), .reg2(reg2),
        .reg1val(n_r1val), .reg2val(n_r2val), .reg1busy(n_r1busy), .reg2busy(n_r2busy),
        .hazard(n_hazard), .issue_valid(issue_valid), .issue_rd(issue_rd), .regD(regD),
        .write_data(write_data), .regwrite(regwrite), .flush(flush), .sb_err(n_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            mreg[r] = '0;
            mcnt[r] = 0;
        end
        merr = 1'b0;
    endtask

    function automatic logic [31:0] exp_val(input int a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && !rst && regwrite && int'(regD) == a) return write_data;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input int a, input bit byp);
        if (a == 0 || mcnt[a] == 0) return 1'b0;
        if (byp && !rst && regwrite && int'(regD) == a && mcnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " b.reg1val"},  b_r1val,  exp_val(reg1, 1));
        chk({tag, " b.reg2val"},  b_r2val,  exp_val(reg2, 1));
        chk({tag, " b.reg1busy"}, 32'(b_r1busy), 32'(exp_busy(reg1, 1)));
        chk({tag, " b.reg2busy"}, 32'(b_r2busy), 32'(exp_busy(reg2, 1)));
        chk({tag, " b.hazard"},   32'(b_hazard), 32'(exp_busy(reg1, 1) | exp_busy(reg2, 1)));
        chk({tag, " b.sb_err"},   32'(b_err),    32'(merr));
        chk({tag, " n.reg1val"},  n_r1val,  exp_val(reg1, 0));
        chk({tag, " n.reg2val"},  n_r2val,  exp_val(reg2, 0));
        chk({tag, " n.reg1busy"}, 32'(n_r1busy), 32'(exp_busy(reg1, 0)));
        chk({tag, " n.reg2busy"}, 32'(n_r2busy), 32'(exp_busy(reg2, 0)));
        chk({tag, " n.hazard"},   32'(n_hazard), 32'(exp_busy(reg1, 0) | exp_busy(reg2, 0)));
        chk({tag, " n.sb_err"},   32'(n_err),    32'(merr));
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
            return;
        end
        for (int r = 1; r < NREG; r++) begin
            bit inc, dec;
            inc = issue_valid && int'(issue_rd) == r;
            dec = regwrite && int'(regD) == r;
            if (flush) mcnt[r] = 0;
            else if (inc && !dec) begin
                if (mcnt[r] == MAXC) merr = 1'b1;
                else mcnt[r]++;
            end else if (dec && !inc) begin
                if (mcnt[r] == 0) merr = 1'b1;
                else mcnt[r]--;
            end
        end
        if (regwrite && regD != 0) mreg[regD] = write_data;
    endtask

    // Inputs are set mid-cycle. Outputs are checked before the edge, then the model advances with the DUT.
    task automatic cycle(input string tag);
        #1;
        if (rst) model_clear();
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; regwrite = 1'b0; flush = 1'b0;
        issue_rd = '0; regD = '0; write_data = '0;
    endtask

    task automatic wb(input int rd, input logic [31:0] d);
        regwrite = 1'b1; regD = AW'(rd); write_data = d;
    endtask

    task automatic iss(input int rd);
        issue_valid = 1'b1; issue_rd = AW'(rd);
    endtask

    initial begin
        model_clear();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        cycle("reset");
        rst = 1'b0;

        wb(5, 32'hDEADBEEF); reg1 = 5;       cycle("wr_x5");
        idle();                               cycle("rd_x5");
        wb(0, 32'h1234); reg1 = 0; reg2 = 5; cycle("wr_x0");
        idle();                               cycle("rd_x0");

        wb(7, 32'h11111111);                  cycle("pre_x7");
        wb(7, 32'hA5A5A5A5); reg1 = 7;       cycle("bypass_x7");
        idle();                               cycle("after_x7");

        reg2 = 3;
        iss(3);                               cycle("iss_x3_a");
        iss(3);                               cycle("iss_x3_b");
        idle();                               cycle("x3_busy2");
        wb(3, 32'h33);                        cycle("x3_wb1");
        wb(3, 32'h34);                        cycle("x3_wb2");
        idle();                               cycle("x3_free");

        reg1 = 4;
        iss(4);                               cycle("iss_x4");
        iss(4); wb(4, 32'h44);                cycle("x4_simul");
        idle();                               cycle("x4_still");
        wb(4, 32'h45);                        cycle("x4_retire");
        idle();

        reg1 = 9;
        for (int i = 0; i < 4; i++) begin
            iss(9);                           cycle("ovf_x9");
        end
        idle();                               cycle("ovf_err");

        #2 rst = 1'b1;                        cycle("rst_mid");
        rst = 1'b0;
        reg1 = 10;
        wb(10, 32'h77);                       cycle("udf_x10");
        idle();                               cycle("udf_read");

        rst = 1'b1;                           cycle("rst2");
        rst = 1'b0;
        iss(1);                               cycle("pend_x1");
        iss(2);                               cycle("pend_x2");
        iss(3);                               cycle("pend_x3");
        reg1 = 2; reg2 = 6;
        flush = 1'b1; iss(6); wb(2, 32'h55); cycle("flush");
        idle();                               cycle("post_flush_a");
        reg1 = 1; reg2 = 3;                   cycle("post_flush_b");

        for (int i = 0; i < 400; i++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = AW'($urandom_range(0, 11));
            regwrite    = ($urandom_range(0, 2) != 0);
            regD        = AW'($urandom_range(0, 11));
            write_data  = $urandom;
            flush       = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 49) == 0);
            reg1        = AW'($urandom_range(0, 11));
            reg2        = AW'($urandom_range(0, 11));
            cycle("random");
        end
        rst = 1'b0;
        idle();
        cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a per-register pending-write scoreboard and optional writeback-to-decode bypass. It sits between decode and writeback in the pipeline. Decode reads two operands and learns whether either has an outstanding write. It also registers each issued instruction's destination. Writeback retires the destination, and a flush discards all outstanding tracking after a branch mispredict or trap.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, register count including x0; power of two, ≥ 2
- CNTW, 2, width of each pending-write counter (max 2^CNTW−1 writes in flight per register)
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = no forwarding

AW = $clog2(NREG).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- reg1, reg2  in  AW  decode read addresses
- reg1val, reg2val  out  XLEN  read data (combinational)
- reg1busy, reg2busy  out  1  operand has an unretired pending write (combinational)
- hazard  out  1  reg1busy | reg2busy
- issue_valid  in  1  decode issues an instruction writing issue_rd
- issue_rd  in  AW  destination of the issued instruction
- regD  in  AW  writeback destination
- write_data  in  XLEN  writeback data
- regwrite  in  1  writeback valid
- flush  in  1  clear all pending counters
- sb_err  out  1  sticky error: counter overflow or underflow

## Operation
- Storage: regs[1..NREG−1] of XLEN bits and cnt[1..NREG−1] of CNTW bits. x0 has no storage and no counter.
- Read: regNval = 0 if regN==0. Otherwise, if BYPASS && regwrite && regD==regN, it is write_data. Otherwise it is regs[regN].
- Write: on an edge with regwrite && regD!=0, regs[regD] <= write_data. Writes to x0 are ignored.
- Busy: regNbusy = 0 if regN==0. Otherwise it is cnt[regN]!=0, except it is forced 0 when BYPASS && regwrite && regD==regN && cnt[regN]==1 (the last pending write is retiring this cycle and its data is forwarded).
- Counter update per register r≠0, evaluated each edge:
  - inc = issue_valid && issue_rd==r; dec = regwrite && regD==r
  - inc && !dec: cnt+1
  - dec && !inc: cnt−1
  - both or neither: cnt unchanged
- Overflow: inc && !dec with cnt at max. cnt holds at max and sb_err is set.
- Underflow: dec && !inc with cnt==0. cnt stays 0 and sb_err is set. The register write still occurs.
- Flush has priority over inc/dec: all cnt <= 0 and no error is flagged. The regwrite data write in the same cycle still occurs. issue_valid in a flush cycle is discarded.
- sb_err clears only on rst.
- issue_rd==0 and regD==0 never affect counters.

## Timing
- Read data, busy and hazard are combinational from addresses and current state. Zero-cycle latency.
- A write is visible through regs the cycle after the edge. With BYPASS=1 it is also visible in the same cycle through the read mux.
- Issue marks busy from the next cycle.
- Reset: while rst is high, all regs = 0, all cnt = 0 and sb_err = 0. Consequently reg1busy, reg2busy and hazard are 0.
  - Bypass is suppressed while rst is high, so reg1val/reg2val read 0.
  - Reset asserted mid-operation discards all pending state immediately, with no clock edge needed.
- No back-pressure. The counter update is single-cycle and unconditional.

## Test plan
- Reset/x0:
  - Assert rst, then write x5=0xDEADBEEF.
  - Read x5 → 0xDEADBEEF next cycle.
  - Write x0=0x1234 and read x0 → 0, busy 0.
  - Assert rst mid-stream → all reads 0 and sb_err 0 without any clock edge.
- Bypass:
  - BYPASS=1: regwrite x7=0xA5A5A5A5 with reg1=7 in the same cycle → reg1val=0xA5A5A5A5 that cycle.
  - BYPASS=0: same stimulus → reg1val holds the old value until the next cycle.
- Scoreboard:
  - issue x3 twice → reg2busy=1 with cnt 2.
  - First writeback x3 → busy remains 1.
  - Second writeback with reg2=3 → busy 0 that cycle (BYPASS=1), hazard 0.
- Simultaneous:
  - issue x4 and writeback x4 in the same cycle with cnt=1 → cnt stays 1, busy stays 1 next cycle.
- Overflow/underflow:
  - CNTW=2: four issues to x9 → cnt saturates at 3, sb_err=1.
  - After reset: writeback x10 with cnt 0 → sb_err=1, x10 is still written.
- Flush:
  - Pend x1, x2 and x3, then assert flush together with issue x6 and writeback x2=0x55.
  - → all busy 0 next cycle, x6 not busy, x2 reads 0x55, sb_err 0.
